uart_rx: RTL
============

# uart_rx

Serial receiver consuming the oversample tick produced by the team's baud-rate counter (its overflow pulse, wired to `tick`). It synchronises the asynchronous `rxd` line and validates the start bit at mid-bit. It shifts in DATA_BITS data bits LSB-first, checks the stop bit, and presents each byte on a valid/ready output holding register. Frame framing errors and overruns are flagged as single-cycle pulses.

## Interface

- `OVS`, default 16: ticks per bit period; even, ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `tick` input 1: oversample enable, one-cycle pulse, nominally every fclk/(baud·OVS) clocks.
- `rxd` input 1: asynchronous serial line, idle high.
- `m_data` output DATA_BITS: received byte; stable while `m_valid` is high.
- `m_valid` output 1: byte available.
- `m_ready` input 1: consumer accepts the byte when `m_valid && m_ready`.
- `busy` output 1: high in any state other than IDLE.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped.

## Operation

- Synchroniser: `rxd` passes through two flops, both reset to 1, giving `rxd_s`. All decisions use `rxd_s`.
- Counters:
  - tick counter `cnt` is $clog2(OVS) wide.
  - bit counter `bit_idx` is $clog2(DATA_BITS) wide.
  - Both change only on `tick`.
- State machine (`rxd_s` is evaluated only on `tick` cycles):
  - IDLE: if `rxd_s`==0, go to START and set `cnt`=0.
  - START: if `cnt`==OVS/2−1 and `rxd_s`==0, go to DATA with `cnt`=0 and `bit_idx`=0. If `cnt`==OVS/2−1 and `rxd_s`==1, this is a false start: return to IDLE. Otherwise increment `cnt`.
  - DATA: if `cnt`==OVS−1, shift `rxd_s` into shift[DATA_BITS−1] (right shift, LSB-first) and set `cnt`=0. After the bit with `bit_idx`==DATA_BITS−1 is shifted, go to STOP; otherwise increment `bit_idx`. If `cnt`≠OVS−1, increment `cnt`.
  - STOP: if `cnt`==OVS−1 and `rxd_s`==1, deliver the shift register and go to IDLE. If `cnt`==OVS−1 and `rxd_s`==0, pulse `frame_err`, discard the byte, and go to BREAK. Otherwise increment `cnt`.
  - BREAK: if `rxd_s`==1, go to IDLE. This prevents a held-low line from being re-read as start bits.
- Delivery when `m_valid`==0, or when `m_valid && m_ready` in the same cycle: load `m_data` and set `m_valid`=1. No overrun.
- Delivery when `m_valid`==1 and `m_ready`==0: the new byte is dropped, `m_data` is held, and `overrun` pulses.
- `m_valid` clears the cycle after `m_valid && m_ready`, unless a delivery replaces the byte in that cycle.
- `tick` is ignored during reset. The state machine never advances without `tick`.

## Timing

- Reset values:
  - state IDLE, `cnt`=0, `bit_idx`=0, shift register 0.
  - synchroniser flops 1.
  - `m_data`=0, `m_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0.
- `rst_n` low mid-frame aborts the frame: no `m_valid` and no `frame_err`, and the outputs take their reset values on the next edge.
- `rxd` to `rxd_s`: 2 clocks.
- Start detection to mid-start check: OVS/2 ticks. Each data sample is OVS ticks after the previous sample.
- `m_valid`, `frame_err` and `overrun` are registered. They assert on the clock edge that processes the stop-bit tick, so they are visible in the cycle following that tick.
- `m_data` is unchanged whenever `m_valid`==1 and no accepted replacement occurs.
- Maximum throughput: one byte per (DATA_BITS+2)·OVS ticks. The next start bit can be detected on the first tick after returning to IDLE.

## Test plan

- **Basic byte:** OVS=16, `tick` every 4 clocks, `m_ready`=1, frame 0xA5 sent 8N1 → exactly one `m_valid` pulse with `m_data`=0xA5. `frame_err`=0, `overrun`=0, and `busy` falls after the stop bit.
- **False start:** `rxd` low for 3 ticks then high → `busy` rises then returns to 0. No `m_valid` and no `frame_err`.
- **Framing error:** frame 0x3C with stop bit 0, then line held low for 2 bit times, then high → one `frame_err` pulse and no `m_valid`. No further activity until the line is high, after which a following 0x11 is received correctly.
- **Overrun:** `m_ready`=0, send 0x55 then 0x0F back-to-back → `m_valid`=1 with `m_data`=0x55 held, and one `overrun` pulse at the end of the second frame. Raising `m_ready` then yields 0x55 only.
- **Simultaneous accept:** `m_valid` high holding 0x01, `m_ready` asserted in the same cycle as delivery of 0x02 → `m_data`=0x02, `m_valid` stays 1, no `overrun`.
- **Reset mid-frame:** assert `rst_n`=0 for 1 clock during data bit 4 of 0xFF → all outputs at reset values. The next full frame 0x80 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: two-flop rxd synchroniser, mid-bit start validation, LSB-first
// shift-in, stop-bit check and a valid/ready output holding register.
module uart_rx #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [BW-1:0]          bit_idx, bit_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic                   deliver, ferr;
  logic                   rxd_p0, rxd_s;

  // stage p0 -> s: metastability synchroniser, idles high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_s  <= rxd_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    deliver = 1'b0;
    ferr    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            if (!rxd_s) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shift_d = {rxd_s, shift[DATA_BITS-1:1]};
            cnt_d   = '0;
            if (bit_idx == BIT_LAST) state_d = STOP;
            else                     bit_d   = bit_idx + 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            if (rxd_s) begin
              deliver = 1'b1;
              state_d = IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = BRK;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        BRK: begin
          // wait out a held-low line so it is not re-read as start bits
          if (rxd_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // output holding register: a new byte only replaces one being accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!m_valid || m_ready) begin
          m_data  <= shift;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
